// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR key controller: FSM states, frame field
// positions, default timing and the frame integrity check.
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RPT   = 2'd3
  } ir_state_e;

  localparam int ADDR_MSB  = 31;
  localparam int ADDR_LSB  = 24;
  localparam int NADDR_MSB = 23;
  localparam int NADDR_LSB = 16;
  localparam int CMD_MSB   = 15;
  localparam int CMD_LSB   = 8;
  localparam int NCMD_MSB  = 7;
  localparam int NCMD_LSB  = 0;

  localparam int DEF_RPT_DLY_MS = 500;
  localparam int DEF_RPT_PER_MS = 100;
  localparam int DEF_HOLD_TO_MS = 120;

  // Accept only our address with both inverted-copy bytes intact
  function automatic logic frame_ok(input logic [31:0] frame, input logic [7:0] addr);
    logic [7:0] a_v, na_v, c_v, nc_v;
    a_v  = frame[ADDR_MSB:ADDR_LSB];
    na_v = frame[NADDR_MSB:NADDR_LSB];
    c_v  = frame[CMD_MSB:CMD_LSB];
    nc_v = frame[NCMD_MSB:NCMD_LSB];
    return (a_v == addr) && ((a_v ^ na_v) == 8'hFF) && ((c_v ^ nc_v) == 8'hFF);
  endfunction

endpackage

// File: rtl/ir_key_ctrl_ms_timer.sv
// Millisecond counter with synchronous clear and terminal-count flag; it
// saturates at the limit so it never wraps while waiting to be cleared.
module ms_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt_r;
  logic         tc_s;

  assign tc_s = (cnt_r >= limit);
  assign tc   = tc_s;

  // Clear wins over tick so a same-cycle restart always starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (tick && !tc_s) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ir_key_ctrl.sv
// NEC remote key controller: validates frames, emits press and auto-repeat
// events, and releases the key when repeat codes stop arriving.
import ir_pkg::*;

module ir_key_ctrl #(
  parameter logic [7:0] P_ADDR    = 8'h00,
  parameter int         P_RPT_DLY = DEF_RPT_DLY_MS,
  parameter int         P_RPT_PER = DEF_RPT_PER_MS,
  parameter int         P_HOLD_TO = DEF_HOLD_TO_MS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_vld,
  input  logic [31:0] i_frame,
  input  logic        i_rpt_vld,
  input  logic        i_tick_1ms,
  output logic        o_key_vld,
  output logic [7:0]  o_key,
  output logic        o_key_rpt,
  output logic        o_release,
  output logic [7:0]  o_err_cnt,
  output logic        o_held
);

  localparam int MAX_A  = (P_RPT_DLY > P_RPT_PER) ? P_RPT_DLY : P_RPT_PER;
  localparam int MAX_MS = (MAX_A > P_HOLD_TO) ? MAX_A : P_HOLD_TO;
  localparam int TW     = $clog2(MAX_MS + 1);

  ir_state_e   state_r;
  logic [31:0] frame_r;
  logic        was_held_r;
  logic        key_vld_r;
  logic [7:0]  key_r;
  logic        key_rpt_r;
  logic        release_r;
  logic [7:0]  err_cnt_r;
  logic        held_r;

  logic          in_hold_s;
  logic          tick_s;
  logic          rpt_clr_s;
  logic          hold_clr_s;
  logic [TW-1:0] rpt_lim_s;
  logic          rpt_tc_s;
  logic          hold_tc_s;

  // Timers only run while a key is held; anything else keeps them at zero
  assign in_hold_s  = (state_r == ST_HOLD) || (state_r == ST_RPT);
  assign tick_s     = in_hold_s && i_tick_1ms;
  assign rpt_clr_s  = !in_hold_s || i_frame_vld || rpt_tc_s;
  assign hold_clr_s = !in_hold_s || i_frame_vld || i_rpt_vld;
  assign rpt_lim_s  = (state_r == ST_RPT) ? TW'(P_RPT_PER) : TW'(P_RPT_DLY);

  ms_timer #(.W(TW)) u_rpt_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (rpt_clr_s),
    .tick  (tick_s),
    .limit (rpt_lim_s),
    .tc    (rpt_tc_s)
  );

  ms_timer #(.W(TW)) u_hold_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (hold_clr_s),
    .tick  (tick_s),
    .limit (TW'(P_HOLD_TO)),
    .tc    (hold_tc_s)
  );

  // Key FSM; a new frame preempts every state, release beats auto-repeat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      frame_r    <= 32'h0000_0000;
      was_held_r <= 1'b0;
      key_vld_r  <= 1'b0;
      key_r      <= 8'h00;
      key_rpt_r  <= 1'b0;
      release_r  <= 1'b0;
      err_cnt_r  <= 8'h00;
      held_r     <= 1'b0;
    end else begin
      key_vld_r <= 1'b0;
      release_r <= 1'b0;
      if (i_frame_vld) begin
        frame_r    <= i_frame;
        was_held_r <= in_hold_s || ((state_r == ST_CHECK) && was_held_r);
        state_r    <= ST_CHECK;
        held_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_CHECK: begin
            if (frame_ok(frame_r, P_ADDR)) begin
              key_vld_r <= 1'b1;
              key_r     <= frame_r[CMD_MSB:CMD_LSB];
              key_rpt_r <= 1'b0;
              state_r   <= ST_HOLD;
              held_r    <= 1'b1;
            end else begin
              err_cnt_r <= (err_cnt_r == 8'hFF) ? err_cnt_r : err_cnt_r + 8'd1;
              release_r <= was_held_r;
              state_r   <= ST_IDLE;
              held_r    <= 1'b0;
            end
            was_held_r <= 1'b0;
          end
          ST_HOLD, ST_RPT: begin
            if (hold_tc_s) begin
              release_r <= 1'b1;
              state_r   <= ST_IDLE;
              held_r    <= 1'b0;
            end else if (rpt_tc_s) begin
              key_vld_r <= 1'b1;
              key_rpt_r <= 1'b1;
              state_r   <= ST_RPT;
              held_r    <= 1'b1;
            end else begin
              state_r <= state_r;
              held_r  <= 1'b1;
            end
          end
          ST_IDLE: begin
            state_r <= ST_IDLE;
            held_r  <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            held_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_key_vld = key_vld_r;
  assign o_key     = key_r;
  assign o_key_rpt = key_rpt_r;
  assign o_release = release_r;
  assign o_err_cnt = err_cnt_r;
  assign o_held    = held_r;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Directed bench for ir_key_ctrl: frame checking, error counting, auto-repeat
// timing, hold timeout, key supersede and reset behaviour.
module tb_ir_key_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_frame_vld = 1'b0;
  logic [31:0] i_frame = 32'h0000_0000;
  logic        i_rpt_vld = 1'b0;
  logic        i_tick_1ms = 1'b0;
  logic        o_key_vld;
  logic [7:0]  o_key;
  logic        o_key_rpt;
  logic        o_release;
  logic [7:0]  o_err_cnt;
  logic        o_held;

  int vec_cnt = 0;
  int miscmp_cnt = 0;
  int both_cnt = 0;
  int rep_q[$];
  int rel_k;
  int press_cnt;
  logic [7:0] rep_key;

  ir_key_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_frame_vld (i_frame_vld),
    .i_frame     (i_frame),
    .i_rpt_vld   (i_rpt_vld),
    .i_tick_1ms  (i_tick_1ms),
    .o_key_vld   (o_key_vld),
    .o_key       (o_key),
    .o_key_rpt   (o_key_rpt),
    .o_release   (o_release),
    .o_err_cnt   (o_err_cnt),
    .o_held      (o_held)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge
  task automatic step(input logic fv, input logic [31:0] fr, input logic rv, input logic tk);
    i_frame_vld = fv;
    i_frame     = fr;
    i_rpt_vld   = rv;
    i_tick_1ms  = tk;
    @(posedge clk);
    #1;
    i_frame_vld = 1'b0;
    i_rpt_vld   = 1'b0;
    i_tick_1ms  = 1'b0;
    if (o_key_vld && o_release) both_cnt++;
  endtask

  // Tick k is 4 clocks: tick, optional repeat code, two idle clocks
  task automatic run_ticks(input int n, input int rpt_every, input int rpt_until);
    rep_q.delete();
    rel_k     = -1;
    press_cnt = 0;
    for (int k = 1; k <= n && rel_k < 0; k++) begin
      for (int s = 0; s < 4; s++) begin
        step(1'b0, 32'h0, (s == 1) && (rpt_every != 0) && (k % rpt_every == 0) && (k <= rpt_until),
             (s == 0));
        if (o_key_vld && o_key_rpt) begin
          rep_q.push_back(k);
          rep_key = o_key;
        end
        if (o_key_vld && !o_key_rpt) press_cnt++;
        if (o_release && rel_k < 0) rel_k = k;
      end
    end
  endtask

  initial begin
    logic [31:0] bad_fr;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_vld", {31'd0, o_key_vld}, 32'd0);
    chk("rst_key", {24'd0, o_key}, 32'd0);
    chk("rst_key_rpt", {31'd0, o_key_rpt}, 32'd0);
    chk("rst_release", {31'd0, o_release}, 32'd0);
    chk("rst_err_cnt", {24'd0, o_err_cnt}, 32'd0);
    chk("rst_held", {31'd0, o_held}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Valid press: event exactly two cycles after the frame strobe
    step(1'b1, 32'h00FF30CF, 1'b0, 1'b0);
    chk("press_lat1", {31'd0, o_key_vld}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("press_vld", {31'd0, o_key_vld}, 32'd1);
    chk("press_key", {24'd0, o_key}, 32'h30);
    chk("press_rpt", {31'd0, o_key_rpt}, 32'd0);
    chk("press_held", {31'd0, o_held}, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("press_one_cycle", {31'd0, o_key_vld}, 32'd0);

    // No repeat codes: release after 120 ms, no auto-repeat
    run_ticks(200, 0, 0);
    chk("to_rel_tick", rel_k, 32'd120);
    chk("to_no_rpt", rep_q.size(), 32'd0);
    chk("to_held", {31'd0, o_held}, 32'd0);

    // Rejected frames count and saturate
    step(1'b1, 32'h00FF30CE, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bad_no_key", {31'd0, o_key_vld}, 32'd0);
    chk("bad_no_rel", {31'd0, o_release}, 32'd0);
    chk("bad_err1", {24'd0, o_err_cnt}, 32'd1);
    for (int i = 0; i < 299; i++) begin
      bad_fr = (i % 3 == 0) ? 32'h01FE30CF : ((i % 3 == 1) ? 32'h00FE30CF : 32'h00FF30CE);
      step(1'b1, bad_fr, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      if (o_key_vld) chk("bad_loop_key", {31'd0, o_key_vld}, 32'd0);
    end
    chk("bad_sat", {24'd0, o_err_cnt}, 32'd255);

    // Bad frame while a key is held releases it
    step(1'b1, 32'h00FF30CF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00FF30CE, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rej_held_rel", {31'd0, o_release}, 32'd1);
    chk("rej_held_held", {31'd0, o_held}, 32'd0);
    chk("rej_held_err", {24'd0, o_err_cnt}, 32'd255);

    // Repeat codes every 108 ms up to 800 ms
    step(1'b1, 32'h00FF30CF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    run_ticks(1000, 108, 800);
    chk("rpt_count", rep_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rep_q.size()) chk("rpt_tick", rep_q[i], 500 + 100 * i);
    end
    chk("rpt_key", {24'd0, rep_key}, 32'h30);
    chk("rpt_rel_tick", rel_k, 32'd876);

    // New key during RPT supersedes old key and restarts the delay
    step(1'b1, 32'h00FF30CF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    run_ticks(550, 108, 100000);
    chk("sup_first_rpt", (rep_q.size() > 0) ? rep_q[0] : -1, 32'd500);
    step(1'b1, 32'h00FF18E7, 1'b1, 1'b1);
    chk("sup_no_rel1", {31'd0, o_release}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sup_vld", {31'd0, o_key_vld}, 32'd1);
    chk("sup_key", {24'd0, o_key}, 32'h18);
    chk("sup_rpt", {31'd0, o_key_rpt}, 32'd0);
    chk("sup_no_rel2", {31'd0, o_release}, 32'd0);
    run_ticks(520, 108, 100000);
    chk("sup_rpt_tick", (rep_q.size() > 0) ? rep_q[0] : -1, 32'd500);
    chk("sup_rpt_key", {24'd0, rep_key}, 32'h18);
    chk("sup_rel_none", rel_k, 32'hFFFF_FFFF);
    chk("sup_held", {31'd0, o_held}, 32'd1);

    // Reset mid-RPT: outputs drop immediately, nothing released afterwards
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_held", {31'd0, o_held}, 32'd0);
    chk("mrst_key", {24'd0, o_key}, 32'd0);
    chk("mrst_err", {24'd0, o_err_cnt}, 32'd0);
    chk("mrst_rpt", {31'd0, o_key_rpt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_ticks(200, 0, 0);
    chk("mrst_no_rel", rel_k, 32'hFFFF_FFFF);
    chk("mrst_no_key", rep_q.size() + press_cnt, 32'd0);
    chk("never_both", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
